// File: rtl/hazard_fwd_ctrl.sv
// REG/DEC hazard controller: EX/MEM scoreboard, forward-mux selects, load-use
// stall with bubble injection, post-branch squash and a saturating stall counter.
module hazard_fwd_ctrl #(
  parameter int REGW         = 5,
  parameter int ZERO_REG     = 31,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [REGW-1:0]  rn,
  input  logic [REGW-1:0]  rb,
  input  logic             uses_a,
  input  logic             uses_b,
  input  logic [REGW-1:0]  dec_rd,
  input  logic             dec_regwrite,
  input  logic             dec_mem2reg,
  input  logic             flush,
  output logic [1:0]       ForwardMuxA,
  output logic [1:0]       ForwardMuxB,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REGW-1:0] ZR     = REGW'(ZERO_REG);
  localparam logic [1:0]      RELOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  logic [1:0]      fcnt;

  logic            ex_v, ex_rw, ex_ld;
  logic [REGW-1:0] ex_rd;
  // The load flag of the MEM slot is never consulted, so it is not stored.
  logic            mem_v, mem_rw;
  logic [REGW-1:0] mem_rd;

  logic ex_a, ex_b, mem_a, mem_b, hz, issue;

  function automatic logic hit(input logic v, input logic rw,
                               input logic [REGW-1:0] rd, input logic [REGW-1:0] r);
    return v & rw & (rd == r) & (r != ZR);
  endfunction

  function automatic logic [1:0] sel(input logic uses, input logic exm,
                                     input logic exld, input logic memm);
    if (!uses)              return 2'b00;
    else if (exm && !exld)  return 2'b01;
    else if (memm)          return 2'b10;
    else                    return 2'b00;
  endfunction

  always_comb begin
    ex_a  = hit(ex_v, ex_rw, ex_rd, rn);
    ex_b  = hit(ex_v, ex_rw, ex_rd, rb);
    mem_a = hit(mem_v, mem_rw, mem_rd, rn);
    mem_b = hit(mem_v, mem_rw, mem_rd, rb);
    hz    = instr_valid & (state == RUN) &
            ((uses_a & ex_a & ex_ld) | (uses_b & ex_b & ex_ld));

    stall  = 1'b0;
    bubble = 1'b1;
    if (reset && state == RUN && !flush) begin
      stall  = hz;
      bubble = hz | ~instr_valid;
    end

    ForwardMuxA = '0;
    ForwardMuxB = '0;
    if (reset && !hz) begin
      ForwardMuxA = sel(uses_a, ex_a, ex_ld, mem_a);
      ForwardMuxB = sel(uses_b, ex_b, ex_ld, mem_b);
    end

    issue = instr_valid & ~stall & ~bubble;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_v        <= 1'b0;
      ex_rw       <= 1'b0;
      ex_ld       <= 1'b0;
      ex_rd       <= '0;
      mem_v       <= 1'b0;
      mem_rw      <= 1'b0;
      mem_rd      <= '0;
      state       <= RUN;
      fcnt        <= '0;
      stall_count <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rw <= ex_rw;
      mem_rd <= ex_rd;
      if (issue) begin
        ex_v  <= 1'b1;
        ex_rw <= dec_regwrite;
        ex_ld <= dec_mem2reg;
        ex_rd <= dec_rd;
      end else begin
        ex_v  <= 1'b0;
        ex_rw <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
      end

      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);

      // fcnt counts squash slots still owed after the current one.
      case (state)
        RUN: begin
          if (flush && FLUSH_CYCLES > 1) begin
            state <= FLUSH;
            fcnt  <= RELOAD;
          end
        end
        FLUSH: begin
          if (flush) begin
            fcnt <= RELOAD;
          end else if (fcnt <= 2'd1) begin
            state <= RUN;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt - 2'd1;
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: two instances (default, and 3-slot flush with a
// 3-bit counter) compared every cycle against a pipeline-history model.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset, instr_valid, uses_a, uses_b, dec_regwrite, dec_mem2reg, flush;
  logic [4:0] rn, rb, dec_rd;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        st0, bu0, st1, bu1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REGW(5), .ZERO_REG(31), .FLUSH_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .rn(rn), .rb(rb),
    .uses_a(uses_a), .uses_b(uses_b), .dec_rd(dec_rd), .dec_regwrite(dec_regwrite),
    .dec_mem2reg(dec_mem2reg), .flush(flush), .ForwardMuxA(fa0), .ForwardMuxB(fb0),
    .stall(st0), .bubble(bu0), .stall_count(cnt0));

  hazard_fwd_ctrl #(.REGW(5), .ZERO_REG(31), .FLUSH_CYCLES(3), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .rn(rn), .rb(rb),
    .uses_a(uses_a), .uses_b(uses_b), .dec_rd(dec_rd), .dec_regwrite(dec_regwrite),
    .dec_mem2reg(dec_mem2reg), .flush(flush), .ForwardMuxA(fa1), .ForwardMuxB(fb1),
    .stall(st1), .bubble(bu1), .stall_count(cnt1));

  // Model: per instance, the last two issued instructions (age 0 = one cycle old).
  typedef struct { bit v; int rd; bit rw; bit ld; } ent_t;
  ent_t hist [2][2];
  int   squash [2];
  int   m_cnt  [2];
  int   fcyc   [2] = '{1, 3};
  int   cmax   [2] = '{65535, 7};
  int   e_fa [2], e_fb [2], e_st [2], e_bu [2];

  function automatic bit produces(ent_t e, int r);
    return e.v && e.rw && e.rd == r && r != 31;
  endfunction

  function automatic int pick(bit use_it, ent_t y, ent_t o, int r);
    if (!use_it) return 0;
    if (produces(y, r) && !y.ld) return 1;
    if (produces(o, r)) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit ua, input bit ub,
                       input int rd, input bit rw, input bit ld, input bit fl, input bit rst);
    instr_valid = v; rn = 5'(a); rb = 5'(b); uses_a = ua; uses_b = ub;
    dec_rd = 5'(rd); dec_regwrite = rw; dec_mem2reg = ld; flush = fl; reset = rst;
    #2;
    for (int k = 0; k < 2; k++) begin
      bit in_fl, hzk;
      in_fl = squash[k] > 0;
      hzk = v && !in_fl &&
            ((ua && produces(hist[k][0], a) && hist[k][0].ld) ||
             (ub && produces(hist[k][0], b) && hist[k][0].ld));
      e_st[k] = (rst && !in_fl && !fl && hzk) ? 1 : 0;
      e_bu[k] = (!rst || in_fl || fl || hzk || !v) ? 1 : 0;
      e_fa[k] = (!rst || hzk) ? 0 : pick(ua, hist[k][0], hist[k][1], a);
      e_fb[k] = (!rst || hzk) ? 0 : pick(ub, hist[k][0], hist[k][1], b);
    end
    chk("fwdA0", fa0, e_fa[0]);  chk("fwdB0", fb0, e_fb[0]);
    chk("stall0", st0, e_st[0]); chk("bubble0", bu0, e_bu[0]);
    chk("count0", cnt0, m_cnt[0]);
    chk("fwdA1", fa1, e_fa[1]);  chk("fwdB1", fb1, e_fb[1]);
    chk("stall1", st1, e_st[1]); chk("bubble1", bu1, e_bu[1]);
    chk("count1", cnt1, m_cnt[1]);
  endtask

  task automatic adv();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        hist[k][0] = '{0, 0, 0, 0};
        hist[k][1] = '{0, 0, 0, 0};
        squash[k]  = 0;
        m_cnt[k]   = 0;
      end else begin
        hist[k][1] = hist[k][0];
        if (e_bu[k] == 0) hist[k][0] = '{1, int'(dec_rd), dec_regwrite, dec_mem2reg};
        else              hist[k][0] = '{0, 0, 0, 0};
        if (e_st[k] == 1 && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (flush)              squash[k] = fcyc[k] - 1;
        else if (squash[k] > 0) squash[k]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      hist[k][0] = '{0, 0, 0, 0};
      hist[k][1] = '{0, 0, 0, 0};
      squash[k] = 0;
      m_cnt[k]  = 0;
    end
    reset = 1'b0; instr_valid = 1'b1; rn = '0; rb = '0; uses_a = 1'b0; uses_b = 1'b0;
    dec_rd = '0; dec_regwrite = 1'b0; dec_mem2reg = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // reset held: quiet outputs
    drive(1, 3, 3, 1, 1, 3, 1, 0, 0, 0);
    chk("rst_bubble", bu0, 1); chk("rst_stall", st0, 0);
    adv();

    // EX then MEM forwarding of X3
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 1); adv();
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 1);
    chk("tp_ex_fwdA", fa0, 1); chk("tp_ex_stall", st0, 0); adv();
    drive(1, 3, 5, 1, 1, 7, 1, 0, 0, 1);
    chk("tp_mem_fwdA", fa0, 2); adv();

    // X3 in both EX and MEM: youngest wins
    drive(1, 1, 1, 1, 1, 3, 1, 0, 0, 1); adv();
    drive(1, 2, 2, 1, 1, 3, 1, 0, 0, 1); adv();
    drive(1, 1, 3, 1, 1, 8, 1, 0, 0, 1);
    chk("tp_prio_fwdB", fb0, 1); adv();

    // load-use: one stall cycle, then MEM forward
    drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 1); adv();
    drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 1);
    chk("tp_lu_stall", st0, 1); chk("tp_lu_bubble", bu0, 1); adv();
    drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 1);
    chk("tp_lu_after_stall", st0, 0); chk("tp_lu_fwdA", fa0, 2); chk("tp_lu_count", cnt0, 1);
    adv();

    // XZR never forwards; unused operand selects regfile
    drive(1, 1, 2, 1, 1, 31, 1, 0, 0, 1); adv();
    drive(1, 31, 31, 1, 1, 9, 1, 0, 0, 1);
    chk("tp_xzr_fwdA", fa0, 0); chk("tp_xzr_fwdB", fb0, 0); adv();
    drive(1, 9, 0, 0, 0, 10, 1, 0, 0, 1);
    chk("tp_unused_fwdA", fa0, 0); adv();

    // load-use coinciding with flush; 3-slot squash on dut1
    drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 1); adv();
    drive(1, 5, 2, 1, 1, 6, 1, 0, 1, 1);
    chk("tp_fl_stall", st0, 0); chk("tp_fl_bubble", bu0, 1); adv();
    drive(1, 1, 2, 1, 1, 11, 1, 0, 0, 1);
    chk("tp_fl_count", cnt0, 1); chk("tp_fl3_slot2", bu1, 1); chk("tp_fl1_issue", bu0, 0); adv();
    drive(1, 1, 2, 1, 1, 12, 1, 0, 0, 1);
    chk("tp_fl3_slot3", bu1, 1); adv();
    drive(1, 1, 2, 1, 1, 13, 1, 0, 0, 1);
    chk("tp_fl3_resume", bu1, 0); adv();

    // reset during a load-use stall
    drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 1); adv();
    drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    chk("tp_rst_stall", st0, 0); chk("tp_rst_fwdA", fa0, 0); adv();
    drive(1, 5, 2, 1, 1, 6, 1, 0, 0, 1);
    chk("tp_rst_count", cnt0, 0); chk("tp_rst_noforward", fa0, 0); chk("tp_rst_nostall", st0, 0);
    adv();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int regs [5];
      regs = '{1, 2, 3, 31, 0};
      regs[4] = int'($urandom_range(0, 31));
      drive($urandom_range(0, 7) != 0,
            regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
            1'($urandom), 1'($urandom),
            regs[$urandom_range(0, 4)], $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 39) != 0);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
